// File: rtl/ha_result_accumulator.sv
// Frame accumulator for half-adder results: sums 2*c+s per beat with saturation,
// counts beats, and presents a held frame result on a valid/ready output port.
module ha_result_accumulator #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_s,
    input  logic         in_c,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_out,
    output logic [W-1:0] beats_out,
    output logic         ovf_out,
    output logic         illegal_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_VAL = '1;

    state_t         state_q, state_d;
    logic [W-1:0]   total_q, total_d;
    logic [W-1:0]   beats_q, beats_d;
    logic           ovf_q, ovf_d;
    logic           ill_q, ill_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   sum_out_q, sum_out_d;
    logic [W-1:0]   beats_out_q, beats_out_d;
    logic           ovf_out_q, ovf_out_d;
    logic           illegal_out_q, illegal_out_d;

    logic           accept;
    logic [1:0]     beat_value;
    logic           beat_illegal;
    logic           start_fresh;
    logic [W-1:0]   base_total;
    logic [W-1:0]   base_beats;
    logic           base_ovf;
    logic           base_ill;
    logic [W:0]     wide_total;
    logic [W-1:0]   beat_total;
    logic [W-1:0]   beat_beats;
    logic           beat_sat;

    // in_ready is a flop of the state decode, so out_ready never reaches it combinationally.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        beat_illegal = in_c & in_s;
        beat_value   = beat_illegal ? 2'd0 : {in_c, in_s};

        // A frame opened in IDLE starts from zero regardless of leftover accumulator state.
        start_fresh  = (state_q == IDLE);
        base_total   = start_fresh ? '0   : total_q;
        base_beats   = start_fresh ? '0   : beats_q;
        base_ovf     = start_fresh ? 1'b0 : ovf_q;
        base_ill     = start_fresh ? 1'b0 : ill_q;

        wide_total   = {1'b0, base_total} + (W+1)'(beat_value);
        beat_sat     = wide_total[W];
        beat_total   = beat_sat ? MAX_VAL : wide_total[W-1:0];
        beat_beats   = (base_beats == MAX_VAL) ? MAX_VAL : base_beats + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    total_d = beat_total;
                    beats_d = beat_beats;
                    ovf_d   = base_ovf | beat_sat;
                    ill_d   = base_ill | beat_illegal;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                    total_d = '0;
                    beats_d = '0;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                total_d = '0;
                beats_d = '0;
                ovf_d   = 1'b0;
                ill_d   = 1'b0;
            end
        endcase

        // Output-port flops track the next state so the result appears the cycle after the last beat.
        in_ready_d    = (state_d != HOLD);
        out_valid_d   = (state_d == HOLD);
        sum_out_d     = out_valid_d ? total_d : '0;
        beats_out_d   = out_valid_d ? beats_d : '0;
        ovf_out_d     = out_valid_d & ovf_d;
        illegal_out_d = out_valid_d & ill_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            total_q       <= '0;
            beats_q       <= '0;
            ovf_q         <= 1'b0;
            ill_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            sum_out_q     <= '0;
            beats_out_q   <= '0;
            ovf_out_q     <= 1'b0;
            illegal_out_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            beats_q       <= beats_d;
            ovf_q         <= ovf_d;
            ill_q         <= ill_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            sum_out_q     <= sum_out_d;
            beats_out_q   <= beats_out_d;
            ovf_out_q     <= ovf_out_d;
            illegal_out_q <= illegal_out_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign sum_out     = sum_out_q;
    assign beats_out   = beats_out_q;
    assign ovf_out     = ovf_out_q;
    assign illegal_out = illegal_out_q;

endmodule

// File: doc/ha_result_accumulator.md
# ha_result_accumulator

Frame accumulator that sits directly downstream of the half adder. Each beat it consumes the adder's sum/carry pair, adds its arithmetic value (2·c + s) into a running total, and counts beats. On the final beat of a frame it presents the total, beat count and status flags on a valid/ready output port, holding them until they are taken. It gives the verification environment a clocked, frame-level result to score against instead of per-vector combinational checks.

## Interface
- `W`, default 8: width of the accumulated total and of the beat counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_s`  in  1  half-adder sum bit.
- `in_c`  in  1  half-adder carry bit.
- `in_last`  in  1  beat is the last of its frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer takes the result.
- `sum_out`  out  W  accumulated total for the frame.
- `beats_out`  out  W  number of beats in the frame.
- `ovf_out`  out  1  the total saturated during the frame.
- `illegal_out`  out  1  a beat with `s=1,c=1` was seen during the frame.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD. Reset enters IDLE.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD.
- Beat value:
  - `{c,s}=00` adds 0.
  - `01` adds 1.
  - `10` adds 2.
  - `11` is illegal: it adds 0, sets the frame's illegal flag, and still counts as a beat.
- Total arithmetic:
  - The total is unsigned, W bits, and saturating.
  - If total + value > 2^W−1, the total becomes 2^W−1 and the frame's overflow flag is set.
  - The overflow flag stays set until the frame ends.
- Beat counter: increments by 1 per accepted beat and saturates at 2^W−1. Saturation of the counter does not set the overflow flag.
- IDLE, on an accepted beat:
  - The accumulators are loaded fresh: total = value, beats = 1, flags come from this beat only.
  - With `in_last=0`, the next state is ACCUM.
  - With `in_last=1`, the next state is HOLD.
- ACCUM, on an accepted beat: the beat is added. With `in_last=1`, the next state is HOLD. With no beat accepted, the state is held.
- HOLD:
  - `out_valid=1`.
  - `sum_out`, `beats_out`, `ovf_out` and `illegal_out` are stable until the handshake `out_valid && out_ready`.
  - On the handshake, the next state is IDLE and the accumulators clear.
- Outside HOLD, `sum_out`, `beats_out`, `ovf_out` and `illegal_out` read 0.
- `in_s`, `in_c` and `in_last` are ignored when `in_valid=0` or `in_ready=0`.

## Timing
- Reset values: `in_ready=0` during the reset cycle and 1 from the first cycle after reset. All other outputs are 0. State is IDLE and all internal accumulators are 0.
- Latency: a last beat accepted at edge N gives `out_valid=1` from cycle N+1, with the last beat's value already included.
- Output handshake: a handshake at edge M gives `out_valid=0` and `in_ready=1` from cycle M+1. This is exactly one cycle in which no beat is accepted between frames.
- `in_ready` depends only on state. There is no combinational path from `out_ready` to `in_ready`.
- Minimum frame: a single beat with `in_last=1`, accepted in IDLE.
- Throughput: one beat per cycle within a frame. Back-to-back frames cost result cycle(s) plus a one-cycle gap.
- `rst` asserted in any state, including mid-frame ACCUM or HOLD with `out_ready=0`: at the next edge the partial frame or pending result is discarded and all outputs take their reset values.
- Simultaneous events: `rst` has priority over every handshake.

## Test plan
- Reset mid-operation: 3 beats in ACCUM, then `rst` for one cycle → `out_valid` stays 0. A following 1-beat frame `{c,s}=10, last` → `sum_out=2`, `beats_out=1`.
- Exhaustive pairs: frame of beats a,b = 00,01,10,11 fed through the half adder, last on the 4th → `sum_out=4`, `beats_out=4`, `ovf_out=0`, `illegal_out=0`.
- Saturation: W=8, 130 beats of `{c,s}=10` → `sum_out=255`, `beats_out=130`, `ovf_out=1`.
- Illegal beat: frame of `01, 11, 10(last)` → `sum_out=3`, `beats_out=3`, `illegal_out=1`, `ovf_out=0`.
- Output backpressure: `out_ready=0` for 5 cycles after a result → `out_valid` and the outputs hold for all 5 cycles and `in_ready=0` throughout. Raising `out_ready` → `in_ready=1` on the next cycle.
- Input stalls: frame `01, gap, gap, 01(last)` with `in_valid=0` in the gaps → `sum_out=2`, `beats_out=2`. Gap beats carrying `s=c=1` with `in_valid=0` are not counted.
